// File: rtl/unidad_de_control_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : unidad_de_control_pkg
//  Contents : Shared opcodes, ALU/branch codes, instruction classes and FSM
//             states for the multi-cycle MIPS control unit.
//             The optional jump state is gated by UNIDAD_DE_CONTROL_JUMP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package unidad_de_control_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALUOP_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SUBI  = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(5);

    localparam logic [1:0] BR_BEQ  = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_BGTZ = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LW      = 3'd1,
        CLS_SW      = 3'd2,
        CLS_IMM     = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_R_EXEC    = 4'd7,
        ST_R_WB      = 4'd8,
        ST_IMM_EXEC  = 4'd9,
        ST_IMM_WB    = 4'd10,
        ST_BRANCH    = 4'd11,
`ifdef UNIDAD_DE_CONTROL_JUMP_EN
        ST_JUMP      = 4'd12,
`endif
        ST_HALT      = 4'd13
    } state_t;

endpackage
`default_nettype wire

// File: rtl/unidad_de_control_multiciclo_if.sv
`default_nettype none
// ============================================================================
//  Module   : unidad_de_control_multiciclo_if
//  Contents : Opcode/handshake inputs and datapath control outputs of the
//             multi-cycle control unit; master = control unit, slave = datapath.
//  Revision : 1.0 - initial release
// ============================================================================
interface unidad_de_control_multiciclo_if;
    import unidad_de_control_pkg::*;

    logic [OPCODE_W-1:0] op_code;
    logic                memReady;
    logic                pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic                memToReg, regDst, regWrite, aluSrcA;
    logic [1:0]          aluSrcB;
    logic [1:0]          pcSource;
    logic [ALUOP_W-1:0]  aluOp;
    logic [1:0]          branchType;
    logic                instrDone;
    logic                halted;

    modport master (
        input  op_code, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource,
               aluOp, branchType, instrDone, halted
    );

    modport slave (
        output op_code, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, pcSource,
               aluOp, branchType, instrDone, halted
    );
endinterface
`default_nettype wire

// File: rtl/unidad_de_control_multiciclo_decode.sv
`default_nettype none
// ============================================================================
//  Module   : control_opcode_decode
//  Contents : Combinational opcode classifier. Opcode 000010 is only legal
//             when UNIDAD_DE_CONTROL_JUMP_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module control_opcode_decode
    import unidad_de_control_pkg::*;
(
    input  logic [OPCODE_W-1:0] op_code_i,
    output instr_class_t        class_o,
    output logic [ALUOP_W-1:0]  imm_alu_op_o,
    output logic [1:0]          branch_type_o,
    output logic                illegal_o
);
    always_comb begin
        class_o       = CLS_ILLEGAL;
        imm_alu_op_o  = ALU_ADD;
        branch_type_o = BR_BEQ;
        case (op_code_i)
            OP_RTYPE: class_o = CLS_RTYPE;
            OP_LW:    class_o = CLS_LW;
            OP_SW:    class_o = CLS_SW;
            OP_ADDI:  begin class_o = CLS_IMM; imm_alu_op_o = ALU_ADD; end
            OP_SUBI:  begin class_o = CLS_IMM; imm_alu_op_o = ALU_SUB; end
            OP_ANDI:  begin class_o = CLS_IMM; imm_alu_op_o = ALU_AND; end
            OP_ORI:   begin class_o = CLS_IMM; imm_alu_op_o = ALU_OR;  end
            OP_SLTI:  begin class_o = CLS_IMM; imm_alu_op_o = ALU_SLT; end
            OP_BEQ:   begin class_o = CLS_BRANCH; branch_type_o = BR_BEQ;  end
            OP_BNE:   begin class_o = CLS_BRANCH; branch_type_o = BR_BNE;  end
            OP_BGTZ:  begin class_o = CLS_BRANCH; branch_type_o = BR_BGTZ; end
`ifdef UNIDAD_DE_CONTROL_JUMP_EN
            OP_J:     class_o = CLS_JUMP;
`endif
            default:  class_o = CLS_ILLEGAL;
        endcase
    end

    assign illegal_o = (class_o == CLS_ILLEGAL);
endmodule
`default_nettype wire

// File: rtl/unidad_de_control_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module   : unidad_de_control_multiciclo
//  Contents : Multi-cycle MIPS main control FSM with memory-ready stalls and
//             sticky halt. Define UNIDAD_DE_CONTROL_JUMP_EN to enable jumps.
//  Revision : 1.0 - initial release
// ============================================================================
module unidad_de_control_multiciclo
    import unidad_de_control_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    unidad_de_control_multiciclo_if.master bus
);
    state_t             state_q, state_d;
    instr_class_t       cls_q, cls_d;
    logic [ALUOP_W-1:0] imm_op_q, imm_op_d;
    logic [1:0]         bt_q, bt_d;

    instr_class_t       w_cls;
    logic [ALUOP_W-1:0] w_imm_op;
    logic [1:0]         w_bt;
    logic               w_illegal;

    control_opcode_decode u_decode (
        .op_code_i     (bus.op_code),
        .class_o       (w_cls),
        .imm_alu_op_o  (w_imm_op),
        .branch_type_o (w_bt),
        .illegal_o     (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RESET;
            cls_q    <= CLS_RTYPE;
            imm_op_q <= ALU_ADD;
            bt_q     <= BR_BEQ;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            imm_op_q <= imm_op_d;
            bt_q     <= bt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cls_d    = cls_q;
        imm_op_d = imm_op_q;
        bt_d     = bt_q;

        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.iorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.irWrite     = 1'b0;
        bus.memToReg    = 1'b0;
        bus.regDst      = 1'b0;
        bus.regWrite    = 1'b0;
        bus.aluSrcA     = 1'b0;
        bus.aluSrcB     = SRCB_REG;
        bus.pcSource    = PCSRC_ALU;
        bus.aluOp       = ALU_ADD;
        bus.branchType  = BR_BEQ;
        bus.instrDone   = 1'b0;
        bus.halted      = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                bus.memRead = 1'b1;
                bus.aluSrcB = SRCB_FOUR;
                bus.irWrite = bus.memReady;
                bus.pcWrite = bus.memReady;
                if (bus.memReady) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                bus.aluSrcB = SRCB_IMM_SH;
                // Decode results are captured here so op_code may change afterwards.
                cls_d    = w_cls;
                imm_op_d = w_imm_op;
                bt_d     = w_bt;
                if (w_illegal) begin
                    state_d = ST_HALT;
                end else begin
                    case (w_cls)
                        CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
                        CLS_RTYPE:      state_d = ST_R_EXEC;
                        CLS_IMM:        state_d = ST_IMM_EXEC;
                        CLS_BRANCH:     state_d = ST_BRANCH;
`ifdef UNIDAD_DE_CONTROL_JUMP_EN
                        CLS_JUMP:       state_d = ST_JUMP;
`endif
                        default:        state_d = ST_HALT;
                    endcase
                end
            end
            ST_MEM_ADDR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = SRCB_IMM;
                state_d     = (cls_q == CLS_SW) ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                bus.memRead = 1'b1;
                bus.iorD    = 1'b1;
                if (bus.memReady) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                bus.regWrite  = 1'b1;
                bus.memToReg  = 1'b1;
                bus.instrDone = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                bus.memWrite  = 1'b1;
                bus.iorD      = 1'b1;
                bus.instrDone = bus.memReady;
                if (bus.memReady) state_d = ST_FETCH;
            end
            ST_R_EXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = ALU_FUNCT;
                state_d     = ST_R_WB;
            end
            ST_R_WB: begin
                bus.regWrite  = 1'b1;
                bus.regDst    = 1'b1;
                bus.instrDone = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_IMM_EXEC: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = SRCB_IMM;
                bus.aluOp   = imm_op_q;
                state_d     = ST_IMM_WB;
            end
            ST_IMM_WB: begin
                bus.regWrite  = 1'b1;
                bus.instrDone = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_BRANCH: begin
                bus.aluSrcA     = 1'b1;
                bus.aluOp       = ALU_SUB;
                bus.pcWriteCond = 1'b1;
                bus.pcSource    = PCSRC_ALUOUT;
                bus.branchType  = bt_q;
                bus.instrDone   = 1'b1;
                state_d         = ST_FETCH;
            end
`ifdef UNIDAD_DE_CONTROL_JUMP_EN
            ST_JUMP: begin
                bus.pcWrite   = 1'b1;
                bus.pcSource  = PCSRC_JUMP;
                bus.instrDone = 1'b1;
                state_d       = ST_FETCH;
            end
`endif
            ST_HALT: bus.halted = 1'b1;
            default: state_d = ST_RESET;
        endcase
    end
endmodule
`default_nettype wire

// File: doc/unidad_de_control_multiciclo.md
# unidad_de_control_multiciclo

Multi-cycle main control FSM for the MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and write-back states. It drives all datapath enables and mux selects, and stalls on a memory-ready handshake. It supports the full current opcode set (R-type, lw, sw, beq, bne, bgtz, addi, subi, andi, ori, slti). It sits between the instruction register's opcode field and the multi-cycle datapath.

## Interface
- OPCODE_W, 6, opcode field width
- ALUOP_W, 3, aluOp width (≥3); codes zero-extended
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op_code  input  OPCODE_W  IR opcode field; sampled only in DECODE
- memReady  input  1  memory completes the current access this cycle
- pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite  output  1 each  datapath enables/selects
- memToReg, regDst, regWrite, aluSrcA  output  1 each
- aluSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- pcSource  output  2  00 ALU result, 01 ALUOut, 10 jump target
- aluOp  output  ALUOP_W  000 add, 001 sub, 010 funct, 011 or, 100 slt, 101 and
- branchType  output  2  00 beq, 01 bne, 10 bgtz; valid while pcWriteCond=1
- instrDone  output  1  one-cycle pulse in an instruction's last state
- halted  output  1  sticky; illegal opcode decoded

## Operation
- States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, IMM_EXEC, IMM_WB, BRANCH, JUMP (macro only), HALT.
- Outputs are decoded from the state. The only exceptions are irWrite, pcWrite in FETCH and the memory-state exits, which also depend on memReady.
- Every output not listed for a state is 0.
- RESET: all outputs 0. Unconditionally → FETCH.
- FETCH:
  - memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=add, pcSource=00.
  - irWrite=pcWrite=memReady.
  - Holds while memReady=0; → DECODE when memReady=1.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=add. Branches on op_code:
  - lw/sw → MEM_ADDR
  - R-type → R_EXEC
  - addi/subi/andi/ori/slti → IMM_EXEC
  - beq/bne/bgtz → BRANCH
  - any other opcode → HALT
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=add. → MEM_READ (lw) or MEM_WRITE (sw); the opcode is held in an internal register.
- MEM_READ: memRead=1, iorD=1. Holds until memReady; → MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, regDst=0, instrDone=1. → FETCH.
- MEM_WRITE: memWrite=1, iorD=1. Holds until memReady; instrDone=memReady; then → FETCH.
- R_EXEC: aluSrcA=1, aluSrcB=00, aluOp=funct. → R_WB.
- R_WB: regWrite=1, regDst=1, memToReg=0, instrDone=1. → FETCH.
- IMM_EXEC: aluSrcA=1, aluSrcB=10, aluOp = add/sub/and/or/slt for addi/subi/andi/ori/slti. → IMM_WB.
- IMM_WB: regWrite=1, regDst=0, memToReg=0, instrDone=1. → FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=sub, pcWriteCond=1, pcSource=01, branchType per opcode, instrDone=1. → FETCH.
- HALT: all enables 0, halted=1. Absorbing; only rst_n leaves it.

## Timing
- Cycles with zero wait states, counting from FETCH entry:
  - branch 3
  - R-type, immediate and sw 4
  - lw 5
- Each memReady=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. The outputs stay stable during the stall.
- rst_n low asynchronously forces RESET and clears halted. This holds mid-instruction, including during a memory stall.
- The first FETCH occurs in the 2nd rising edge after rst_n deasserts.
- op_code is ignored outside DECODE. Changes in other states have no effect.
- memReady is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

## Configuration
- UNIDAD_DE_CONTROL_JUMP_EN defined:
  - op_code 000010 in DECODE → JUMP.
  - JUMP: pcWrite=1, pcSource=10, instrDone=1, then → FETCH. 3 cycles total.
- Undefined: 000010 is illegal → HALT. The JUMP state does not exist.

## Structure
- Package unidad_de_control_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BGTZ, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI, OP_J)
  - state encodings
  - aluOp and branchType codes
- Sub-module control_opcode_decode is combinational: op_code → instruction class, imm aluOp, branchType and an illegal flag. The FSM registers these results in DECODE.

## Test plan
- Reset, then lw (100011) with memReady=1 → states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB. instrDone pulses in cycle 5; regWrite=1, memToReg=1 there.
- sw (101011) with memReady low for 2 cycles in MEM_WRITE → memWrite held 3 cycles. instrDone on the memReady=1 cycle; total 6 cycles.
- bne (000101) → BRANCH in cycle 3 with pcWriteCond=1, branchType=01, aluOp=001, pcSource=01.
- ori (001101) → IMM_EXEC aluOp=011 and aluSrcB=10; IMM_WB regWrite=1, regDst=0.
- op_code 111111 in DECODE → halted=1, all enables 0 for 10+ cycles. rst_n pulse → halted=0 and RESET → FETCH.
- 000010 → JUMP with pcSource=10 when the macro is defined; halted=1 when it is not. rst_n asserted mid-MEM_READ → all outputs 0 immediately.
